uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of byte entries; power of two, minimum 2.
REQ-002 Parameter: WIDTH, 8, data bits per entry.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: DataIn  input  WIDTH  byte from the UART receiver.
REQ-006 Port: DataInEn  input  1  one-cycle write strobe qualifying DataIn.
REQ-007 Port: Data  output  WIDTH  head-of-queue byte to the control stage.
REQ-008 Port: DataEn  output  1  high while Data is valid (queue not empty).
REQ-009 Port: DataAck  input  1  consumer pops the head entry this cycle.
REQ-010 Port: Count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 Port: Full  output  1  Count == DEPTH.
REQ-012 Port: Empty  output  1  Count == 0; always equals ~DataEn.
REQ-013 Port: Overflow  output  1  sticky flag; a byte was dropped.
REQ-014 Port: OvfClr  input  1  one-cycle clear of Overflow.

Function
REQ-015 Push: DataInEn=1 and (Full=0 or pop this cycle) -> write DataIn at the write pointer; advance the write pointer.
REQ-016 Pop: DataAck=1 and DataEn=1 -> advance the read pointer; DataAck while Empty is ignored.
REQ-017 Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-018 Count: +1 on push only, -1 on pop only, unchanged on push+pop.
REQ-019 First-word fall-through: Data = storage[read pointer] combinationally; a byte pushed into an empty queue at edge N shows DataEn=1 and valid Data after edge N.
REQ-020 Push+pop while Full: both are accepted; Count stays DEPTH; Overflow is not set.
REQ-021 Push+pop while Empty: the push is accepted and the pop is ignored; Count becomes 1.
REQ-022 DataInEn while Full and no pop: the byte is dropped; storage and pointers are unchanged; Overflow <= 1.
REQ-023 OvfClr=1 clears Overflow; if a drop occurs in the same cycle, set wins and Overflow stays 1.
REQ-024 Full, Empty, DataEn and Count are derived from registered pointers/count only; there is no combinational path from DataInEn to any output.
REQ-025 Data and DataEn are held stable until popped; the consumer may hold DataAck low indefinitely.

Reset
REQ-026 Reset=1 asynchronously sets: pointers=0, Count=0, Empty=1, Full=0, DataEn=0, Overflow=0, all storage=0 (so Data=0).
REQ-027 Reset mid-operation discards all queued bytes; the first push after release lands at entry 0.
REQ-028 A DataInEn coincident with the reset-release edge is ignored.

Structure
REQ-029 Shared package uart_pkg holds: UART_BYTE_W=8, RX_FIFO_DEPTH=16, and the byte typedef used by the receiver, control and transmitter stages.
REQ-030 One sub-module, fifo_mem: register array with one synchronous write port and one asynchronous read port; pointers and flags stay in uart_rx_fifo.

Verification
REQ-031 Push 8'hA5 into an empty queue -> after one edge: DataEn=1, Data=8'hA5, Count=1; DataAck for one cycle -> Empty=1, Count=0.
REQ-032 Push 8'h00..8'h0F with no pops -> Full=1, Count=16; pop all -> bytes emerge in order 8'h00..8'h0F, then Empty=1.
REQ-033 Full queue, push 8'hFF with no pop -> Overflow=1, Count=16, head remains 8'h00; OvfClr -> Overflow=0.
REQ-034 Full queue, push 8'h55 with DataAck in the same cycle -> Count=16, Overflow=0; 8'h55 is popped last.
REQ-035 Run 40 push/pop pairs so the pointers wrap twice -> data order is preserved and Count never exceeds 16 or underflows.
REQ-036 Assert reset with 5 entries queued -> Count=0, DataEn=0, Data=0 immediately (asynchronous); a push of 8'h3C after release is popped as 8'h3C.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the byte type used by every stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module      : fifo_mem
// Description : Register array, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Every entry clears on reset so the head reads as zero afterwards.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
                r_mem[i] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word fall-through receive byte queue with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int WIDTH = UART_BYTE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     DataInEn,
    output logic [WIDTH-1:0]         Data,
    output logic                     DataEn,
    input  logic                     DataAck,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow,
    input  logic                     OvfClr
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = DataAck && !w_empty;
    // A pop frees the slot in the same edge, so a full queue still accepts.
    assign w_push  = DataInEn && (!w_full || w_pop);
    assign w_drop  = DataInEn && w_full && !w_pop;

    fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (c_PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (DataIn),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (Data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (OvfClr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign Count    = r_count;
    assign Full     = w_full;
    assign Empty    = w_empty;
    assign DataEn   = !w_empty;
    assign Overflow = r_overflow;

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench for uart_rx_fifo with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int c_DEPTH = 16;

    logic       clk;
    logic       reset;
    logic [7:0] DataIn;
    logic       DataInEn;
    logic [7:0] Data;
    logic       DataEn;
    logic       DataAck;
    logic [4:0] Count;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       OvfClr;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_cnt = 0;
    logic [7:0] sb[$];

    uart_rx_fifo #(.DEPTH(c_DEPTH), .WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .DataIn   (DataIn),
        .DataInEn (DataInEn),
        .Data     (Data),
        .DataEn   (DataEn),
        .DataAck  (DataAck),
        .Count    (Count),
        .Full     (Full),
        .Empty    (Empty),
        .Overflow (Overflow),
        .OvfClr   (OvfClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && DataEn && DataAck) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", Data);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                if (Data !== exp_b) begin
                    n_bad++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t",
                             Data, exp_b, $time);
                end
            end
        end
    end

    // Called just after a rising edge; applies one cycle of stimulus.
    task automatic step(input logic en, input logic [7:0] d,
                        input logic ack, input logic clr);
        bit pop;
        bit push;
        pop  = ack && (m_cnt > 0);
        push = en && ((m_cnt < c_DEPTH) || pop);
        DataInEn = en;
        DataIn   = d;
        DataAck  = ack;
        OvfClr   = clr;
        if (push) sb.push_back(d);
        @(posedge clk);
        #1;
        DataInEn = 1'b0;
        DataAck  = 1'b0;
        OvfClr   = 1'b0;
        m_cnt = m_cnt + int'(push) - int'(pop);
        chk("count", int'(Count), m_cnt);
        chk("empty_eq_not_dataen", int'(Empty), int'(!DataEn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        DataIn   = 8'h99;
        DataInEn = 1'b1;
        DataAck  = 1'b0;
        OvfClr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        DataInEn = 1'b0;
        reset    = 1'b0;

        chk("rst_count", int'(Count), 0);
        chk("rst_empty", int'(Empty), 1);
        chk("rst_full", int'(Full), 0);
        chk("rst_dataen", int'(DataEn), 0);
        chk("rst_overflow", int'(Overflow), 0);
        chk("rst_data", int'(Data), 0);

        // Single byte round trip.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5_dataen", int'(DataEn), 1);
        chk("a5_data", int'(Data), 8'hA5);
        chk("a5_count", int'(Count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("a5_empty_after_pop", int'(Empty), 1);
        chk("a5_count_after_pop", int'(Count), 0);

        // Ack while empty is ignored.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ack_empty_count", int'(Count), 0);

        // Fill to full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", int'(Full), 1);
        chk("fill_count", int'(Count), 16);
        chk("fill_head", int'(Data), 8'h00);

        // Drop while full.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_overflow", int'(Overflow), 1);
        chk("drop_count", int'(Count), 16);
        chk("drop_head", int'(Data), 8'h00);
        // Drop and clear together: set wins.
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("set_wins_overflow", int'(Overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_overflow", int'(Overflow), 0);

        // Push and pop on a full queue.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("full_pp_count", int'(Count), 16);
        chk("full_pp_overflow", int'(Overflow), 0);
        chk("full_pp_full", int'(Full), 1);
        chk("full_pp_head", int'(Data), 8'h01);

        // Drain: 01..0F then 55.
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", int'(Empty), 1);
        chk("drain_dataen", int'(DataEn), 0);

        // Push and pop on an empty queue: only the push lands.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_pp_count", int'(Count), 1);
        chk("empty_pp_data", int'(Data), 8'h77);

        // 40 simultaneous push/pop pairs wrap both pointers.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            chk("wrap_count", int'(Count), 1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_empty", int'(Empty), 1);

        // Asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("pre_reset_count", int'(Count), 5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", int'(Count), 0);
        chk("async_rst_dataen", int'(DataEn), 0);
        chk("async_rst_data", int'(Data), 0);
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_data", int'(Data), 8'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_empty", int'(Empty), 1);

        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx_fifo

`default_nettype wire
